// File: rtl/pong_pkg.sv
// Shared types and geometry helpers for the Pong engine: match states,
// direction bit meanings, default playfield constants and centring functions.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SERVE    = 3'd1,
      ST_PLAY     = 3'd2,
      ST_PAUSE    = 3'd3,
      ST_GAMEOVER = 3'd4
   } state_t;

   // Direction bits: dir_x set means moving left, dir_y set means moving up.
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;
   localparam logic DIR_DOWN  = 1'b0;
   localparam logic DIR_UP    = 1'b1;

   localparam int DEF_H_RES        = 640;
   localparam int DEF_V_RES        = 480;
   localparam int DEF_BALL_SIZE    = 16;
   localparam int DEF_PAD_W        = 16;
   localparam int DEF_PAD_H        = 128;
   localparam int DEF_TICK_DIV     = 500000;
   localparam int DEF_PAD_SPEED    = 2;
   localparam int DEF_MAX_SPEED    = 4;
   localparam int DEF_SPEEDUP_HITS = 4;
   localparam int DEF_WIN_SCORE    = 9;
   localparam int DEF_SERVE_TICKS  = 100;

   function automatic logic [9:0] centre_x(input int h_res, input int ball_size);
      return 10'((h_res - ball_size) / 2);
   endfunction

   function automatic logic [9:0] centre_y(input int v_res, input int ball_size);
      return 10'((v_res - ball_size) / 2);
   endfunction

   function automatic logic [9:0] pad_centre(input int v_res, input int pad_h);
      return 10'((v_res - pad_h) / 2);
   endfunction

endpackage

// File: rtl/pong_tick_gen.sv
// Game-tick clock enable: a one-cycle registered pulse every TICK_DIV clocks,
// high exactly while the internal counter sits at TICK_DIV-1.
module pong_tick_gen #(
   parameter int TICK_DIV = 500000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = (cnt == LAST) ? '0 : cnt + CW'(1);
   end

   // The pulse is registered from the next count so it lines up with cnt == LAST.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         cnt  <= cnt_next;
         tick <= (cnt_next == LAST);
      end
   end

endmodule

// File: rtl/pong_core.sv
// Pong game engine: paddles, ball motion, scoring and the match FSM, all
// advanced once per game tick and presented on registered outputs.
module pong_core
   import pong_pkg::*;
#(
   parameter int H_RES        = DEF_H_RES,
   parameter int V_RES        = DEF_V_RES,
   parameter int BALL_SIZE    = DEF_BALL_SIZE,
   parameter int PAD_W        = DEF_PAD_W,
   parameter int PAD_H        = DEF_PAD_H,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int PAD_SPEED    = DEF_PAD_SPEED,
   parameter int MAX_SPEED    = DEF_MAX_SPEED,
   parameter int SPEEDUP_HITS = DEF_SPEEDUP_HITS,
   parameter int WIN_SCORE    = DEF_WIN_SCORE,
   parameter int SERVE_TICKS  = DEF_SERVE_TICKS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       l_up,
   input  logic       l_dn,
   input  logic       r_up,
   input  logic       r_dn,
   input  logic       start,
   input  logic       pause,
   output logic [9:0] ball_x,
   output logic [9:0] ball_y,
   output logic [9:0] l_pad_y,
   output logic [9:0] r_pad_y,
   output logic [3:0] l_score,
   output logic [3:0] r_score,
   output logic [2:0] state,
   output logic       winner,
   output logic       tick
);

   localparam int SCW = $clog2(SERVE_TICKS + 1);
   localparam int HCW = 8;

   localparam logic [10:0] BS      = 11'(BALL_SIZE);
   localparam logic [10:0] PH      = 11'(PAD_H);
   localparam logic [10:0] PSPD    = 11'(PAD_SPEED);
   localparam logic [10:0] PAD_MAX = 11'(V_RES - PAD_H);
   localparam logic [10:0] Y_MAX   = 11'(V_RES - BALL_SIZE);
   localparam logic [10:0] X_MAX   = 11'(H_RES - BALL_SIZE);
   localparam logic [10:0] L_FACE  = 11'(PAD_W);
   localparam logic [10:0] R_FACE  = 11'(H_RES - PAD_W - BALL_SIZE);
   localparam logic [9:0]  CX      = centre_x(H_RES, BALL_SIZE);
   localparam logic [9:0]  CY      = centre_y(V_RES, BALL_SIZE);
   localparam logic [9:0]  PAD_C   = pad_centre(V_RES, PAD_H);
   localparam logic [3:0]  MAXS    = 4'(MAX_SPEED);
   localparam logic [3:0]  WIN     = 4'(WIN_SCORE);

   state_t         st, n_st;
   logic [9:0]     bx, by, lpy, rpy;
   logic [9:0]     n_bx, n_by, n_lpy, n_rpy;
   logic [3:0]     ls, rs, n_ls, n_rs;
   logic [3:0]     spd, n_spd;
   logic [HCW-1:0] hits, n_hits;
   logic [SCW-1:0] serve_cnt, n_serve_cnt;
   logic           win, n_win;
   logic           dir_x, n_dir_x;
   logic           dir_y, n_dir_y;

   logic [10:0]    bx_w, by_w, lp_w, rp_w, sp_w;
   logic           ovl_l, ovl_r, hit, miss_l, miss_r;

   pong_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   // 11-bit views keep the edge arithmetic free of wrap-around.
   assign bx_w = {1'b0, bx};
   assign by_w = {1'b0, by};
   assign lp_w = {1'b0, lpy};
   assign rp_w = {1'b0, rpy};
   assign sp_w = {7'd0, spd};

   function automatic logic [9:0] pad_next(input logic [9:0] y, input logic up, input logic dn);
      logic [10:0] w;
      w = {1'b0, y};
      if (up && !dn) begin
         w = (w > PSPD) ? w - PSPD : '0;
      end else if (dn && !up) begin
         w = (w + PSPD > PAD_MAX) ? PAD_MAX : w + PSPD;
      end
      return 10'(w);
   endfunction

   always_comb begin
      n_st        = st;
      n_bx        = bx;
      n_by        = by;
      n_lpy       = lpy;
      n_rpy       = rpy;
      n_ls        = ls;
      n_rs        = rs;
      n_spd       = spd;
      n_hits      = hits;
      n_serve_cnt = serve_cnt;
      n_win       = win;
      n_dir_x     = dir_x;
      n_dir_y     = dir_y;
      hit         = 1'b0;
      miss_l      = 1'b0;
      miss_r      = 1'b0;
      ovl_l       = (by_w + BS > lp_w) && (by_w < lp_w + PH);
      ovl_r       = (by_w + BS > rp_w) && (by_w < rp_w + PH);

      case (st)
         ST_IDLE, ST_GAMEOVER: begin
            if (start) begin
               n_st        = ST_SERVE;
               n_ls        = '0;
               n_rs        = '0;
               n_spd       = 4'd1;
               n_hits      = '0;
               n_bx        = CX;
               n_by        = CY;
               n_serve_cnt = SCW'(SERVE_TICKS);
            end
         end

         ST_SERVE: begin
            n_lpy = pad_next(lpy, l_up, l_dn);
            n_rpy = pad_next(rpy, r_up, r_dn);
            if (serve_cnt <= SCW'(1)) begin
               n_st = ST_PLAY;
            end else begin
               n_serve_cnt = serve_cnt - SCW'(1);
            end
         end

         ST_PLAY: begin
            if (pause) begin
               n_st = ST_PAUSE;
            end else begin
               n_lpy = pad_next(lpy, l_up, l_dn);
               n_rpy = pad_next(rpy, r_up, r_dn);

               if (dir_y == DIR_UP) begin
                  if (by_w <= sp_w) begin
                     n_by    = '0;
                     n_dir_y = DIR_DOWN;
                  end else begin
                     n_by = 10'(by_w - sp_w);
                  end
               end else if (by_w >= Y_MAX - sp_w) begin
                  n_by    = 10'(Y_MAX);
                  n_dir_y = DIR_UP;
               end else begin
                  n_by = 10'(by_w + sp_w);
               end

               if (dir_x == DIR_LEFT) begin
                  if (bx_w <= L_FACE + sp_w && ovl_l) begin
                     n_bx    = 10'(L_FACE);
                     n_dir_x = DIR_RIGHT;
                     hit     = 1'b1;
                  end else if (bx_w <= sp_w) begin
                     miss_l = 1'b1;
                  end else begin
                     n_bx = 10'(bx_w - sp_w);
                  end
               end else begin
                  if (bx_w >= R_FACE - sp_w && ovl_r) begin
                     n_bx    = 10'(R_FACE);
                     n_dir_x = DIR_LEFT;
                     hit     = 1'b1;
                  end else if (bx_w >= X_MAX - sp_w) begin
                     miss_r = 1'b1;
                  end else begin
                     n_bx = 10'(bx_w + sp_w);
                  end
               end

               if (hit) begin
                  if (hits == HCW'(SPEEDUP_HITS - 1)) begin
                     n_hits = '0;
                     if (spd < MAXS) n_spd = spd + 4'd1;
                  end else begin
                     n_hits = hits + HCW'(1);
                  end
               end

               // A point re-centres the ball and serves toward whoever conceded.
               if (miss_l || miss_r) begin
                  n_bx        = CX;
                  n_by        = CY;
                  n_spd       = 4'd1;
                  n_hits      = '0;
                  n_dir_y     = DIR_UP;
                  n_serve_cnt = SCW'(SERVE_TICKS);
                  n_st        = ST_SERVE;
                  if (miss_l) begin
                     n_rs    = rs + 4'd1;
                     n_dir_x = DIR_LEFT;
                     if (rs + 4'd1 == WIN) begin
                        n_st  = ST_GAMEOVER;
                        n_win = 1'b1;
                     end
                  end else begin
                     n_ls    = ls + 4'd1;
                     n_dir_x = DIR_RIGHT;
                     if (ls + 4'd1 == WIN) begin
                        n_st  = ST_GAMEOVER;
                        n_win = 1'b0;
                     end
                  end
               end
            end
         end

         ST_PAUSE: begin
            if (!pause) n_st = ST_PLAY;
         end

         default: n_st = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         bx        <= CX;
         by        <= CY;
         lpy       <= PAD_C;
         rpy       <= PAD_C;
         ls        <= '0;
         rs        <= '0;
         spd       <= 4'd1;
         hits      <= '0;
         serve_cnt <= '0;
         win       <= 1'b0;
         dir_x     <= DIR_RIGHT;
         dir_y     <= DIR_UP;
      end else if (tick) begin
         st        <= n_st;
         bx        <= n_bx;
         by        <= n_by;
         lpy       <= n_lpy;
         rpy       <= n_rpy;
         ls        <= n_ls;
         rs        <= n_rs;
         spd       <= n_spd;
         hits      <= n_hits;
         serve_cnt <= n_serve_cnt;
         win       <= n_win;
         dir_x     <= n_dir_x;
         dir_y     <= n_dir_y;
      end
   end

   assign ball_x  = bx;
   assign ball_y  = by;
   assign l_pad_y = lpy;
   assign r_pad_y = rpy;
   assign l_score = ls;
   assign r_score = rs;
   assign state   = st;
   assign winner  = win;

endmodule

// File: tb/tb_pong_core.sv
// Bench for pong_core: a signed-velocity game model predicts every output each
// cycle, and directed scenarios pin serve timing, bounces, speed-up and scoring.
module tb_pong_core;
   import pong_pkg::*;

   localparam int TD = 4;
   localparam int STK = 3;
   localparam int H = 640;
   localparam int V = 480;
   localparam int B = 16;
   localparam int PW = 16;
   localparam int PH = 128;
   localparam int PS = 2;
   localparam int MS = 4;
   localparam int SH = 4;
   localparam int WS = 9;

   logic       clk = 1'b0;
   logic       rst, l_up, l_dn, r_up, r_dn, start, pause;
   logic [9:0] ball_x, ball_y, l_pad_y, r_pad_y;
   logic [3:0] l_score, r_score;
   logic [2:0] state;
   logic       winner, tick;

   pong_core #(
      .TICK_DIV    (TD),
      .SERVE_TICKS (STK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .l_up    (l_up),
      .l_dn    (l_dn),
      .r_up    (r_up),
      .r_dn    (r_dn),
      .start   (start),
      .pause   (pause),
      .ball_x  (ball_x),
      .ball_y  (ball_y),
      .l_pad_y (l_pad_y),
      .r_pad_y (r_pad_y),
      .l_score (l_score),
      .r_score (r_score),
      .state   (state),
      .winner  (winner),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int m_bx, m_by, m_lp, m_rp, m_ls, m_rs, m_st, m_win;
   int m_s, m_hits, m_sx, m_sy, m_serve, m_cnt, m_tick, m_total_hits;
   bit ev_lhit, ev_rhit, ev_top, ev_point;

   function automatic int clampi(input int v, input int lo, input int hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

   function automatic int pad_move(input int y, input logic up, input logic dn);
      int d;
      d = 0;
      if (up && !dn) d = -PS;
      if (dn && !up) d = PS;
      return clampi(y + d, 0, V - PH);
   endfunction

   task automatic m_reset();
      m_st = ST_IDLE; m_bx = (H - B) / 2; m_by = (V - B) / 2;
      m_lp = (V - PH) / 2; m_rp = (V - PH) / 2;
      m_ls = 0; m_rs = 0; m_win = 0; m_s = 1; m_hits = 0;
      m_sx = 1; m_sy = -1; m_serve = 0; m_cnt = 0; m_tick = 0;
   endtask

   task automatic m_point(input bit right_scored);
      if (right_scored) begin
         m_rs++; m_sx = -1;
         if (m_rs == WS) begin m_st = ST_GAMEOVER; m_win = 1; end else m_st = ST_SERVE;
      end else begin
         m_ls++; m_sx = 1;
         if (m_ls == WS) begin m_st = ST_GAMEOVER; m_win = 0; end else m_st = ST_SERVE;
      end
      m_sy = -1; m_bx = (H - B) / 2; m_by = (V - B) / 2;
      m_s = 1; m_hits = 0; m_serve = STK; ev_point = 1;
   endtask

   task automatic m_play();
      int nx, ny;
      bit ovl, ovr, hit, miss_l, miss_r;
      ovl = (m_by + B > m_lp) && (m_by < m_lp + PH);
      ovr = (m_by + B > m_rp) && (m_by < m_rp + PH);
      hit = 0; miss_l = 0; miss_r = 0;
      ny = m_by + m_sy * m_s;
      if (m_sy < 0 && ny <= 0) begin ny = 0; m_sy = 1; ev_top = 1; end
      else if (m_sy > 0 && ny >= V - B) begin ny = V - B; m_sy = -1; end
      nx = m_bx + m_sx * m_s;
      if (m_sx < 0) begin
         if (nx <= PW && ovl) begin nx = PW; m_sx = 1; hit = 1; ev_lhit = 1; end
         else if (nx <= 0) miss_l = 1;
      end else begin
         if (nx >= H - PW - B && ovr) begin nx = H - PW - B; m_sx = -1; hit = 1; ev_rhit = 1; end
         else if (nx >= H - B) miss_r = 1;
      end
      m_lp = pad_move(m_lp, l_up, l_dn);
      m_rp = pad_move(m_rp, r_up, r_dn);
      m_bx = nx; m_by = ny;
      if (hit) begin
         m_total_hits++;
         m_hits++;
         if (m_hits == SH) begin m_hits = 0; if (m_s < MS) m_s++; end
      end
      if (miss_l) m_point(1);
      if (miss_r) m_point(0);
   endtask

   task automatic m_game();
      ev_lhit = 0; ev_rhit = 0; ev_top = 0; ev_point = 0;
      case (m_st)
         ST_IDLE, ST_GAMEOVER:
            if (start) begin
               m_st = ST_SERVE; m_ls = 0; m_rs = 0; m_s = 1; m_hits = 0;
               m_bx = (H - B) / 2; m_by = (V - B) / 2; m_serve = STK;
            end
         ST_SERVE: begin
            m_lp = pad_move(m_lp, l_up, l_dn);
            m_rp = pad_move(m_rp, r_up, r_dn);
            m_serve--;
            if (m_serve == 0) m_st = ST_PLAY;
         end
         ST_PLAY: if (pause) m_st = ST_PAUSE; else m_play();
         ST_PAUSE: if (!pause) m_st = ST_PLAY;
         default: m_st = ST_IDLE;
      endcase
   endtask

   always @(posedge clk) begin
      if (rst) m_reset();
      else begin
         if (m_cnt == TD - 1) m_game();
         m_cnt = (m_cnt == TD - 1) ? 0 : m_cnt + 1;
         m_tick = (m_cnt == TD - 1) ? 1 : 0;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         chk("ball_x", 32'(ball_x), m_bx);
         chk("ball_y", 32'(ball_y), m_by);
         chk("l_pad_y", 32'(l_pad_y), m_lp);
         chk("r_pad_y", 32'(r_pad_y), m_rp);
         chk("l_score", 32'(l_score), m_ls);
         chk("r_score", 32'(r_score), m_rs);
         chk("state", 32'(state), m_st);
         chk("winner", 32'(winner), m_win);
         chk("tick", 32'(tick), m_tick);
      end
   end

   // ---------------- driver helpers ----------------
   task automatic next_tick();
      int guard;
      guard = 0;
      while (m_tick == 0 && guard < 2 * TD) begin
         @(negedge clk);
         guard++;
      end
      @(negedge clk);
   endtask

   // mode 0 = hold, 1 = track the ball, 2 = move away from the ball
   task automatic steer(input int mode, input int p, output logic up, output logic dn);
      int tgt;
      tgt = m_by + B / 2 - PH / 2;
      up = 1'b0;
      dn = 1'b0;
      case (mode)
         1: begin up = (p > tgt + 2); dn = (p < tgt - 2); end
         2: if (m_by + B / 2 < V / 2) dn = 1'b1; else up = 1'b1;
         default: ;
      endcase
   endtask

   task automatic play_tick(input int lmode, input int rmode);
      steer(lmode, m_lp, l_up, l_dn);
      steer(rmode, m_rp, r_up, r_dn);
      next_tick();
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_state"}, 32'(state), 0);
      chk({tag, "_ball_x"}, 32'(ball_x), 312);
      chk({tag, "_ball_y"}, 32'(ball_y), 232);
      chk({tag, "_l_pad"}, 32'(l_pad_y), 176);
      chk({tag, "_r_pad"}, 32'(r_pad_y), 176);
      chk({tag, "_scores"}, {24'd0, l_score, r_score}, 0);
      chk({tag, "_winner"}, 32'(winner), 0);
      chk({tag, "_tick"}, 32'(tick), 0);
   endtask

   int  cap_x, cap_y, d;
   bit  sp_done, first_point;

   initial begin
      rst = 1'b1; l_up = 0; l_dn = 0; r_up = 0; r_dn = 0; start = 0; pause = 0;
      repeat (3) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;
      chk_reset_values("reset");

      // Start, then serve countdown with both left buttons held (no motion).
      start = 1'b1;
      next_tick();
      start = 1'b0;
      chk("start_serve", 32'(state), 1);
      l_up = 1'b1; l_dn = 1'b1;
      next_tick();
      chk("both_buttons_hold", 32'(l_pad_y), 176);
      l_up = 1'b0; l_dn = 1'b0;
      next_tick();
      chk("serve_2", 32'(state), 1);
      next_tick();
      chk("serve_done_play", 32'(state), 2);
      chk("serve_ball_held", 32'(ball_x), 312);
      next_tick();
      chk("first_move_x", 32'(ball_x), 313);
      chk("first_move_y", 32'(ball_y), 231);

      // Drive the left paddle into the top stop and keep pushing.
      l_up = 1'b1;
      repeat (95) next_tick();
      chk("pad_clamp_top", 32'(l_pad_y), 0);
      l_up = 1'b0;

      // Pause freezes everything for ten ticks.
      pause = 1'b1;
      next_tick();
      chk("pause_state", 32'(state), 3);
      cap_x = m_bx; cap_y = m_by;
      repeat (10) next_tick();
      chk("pause_hold_x", 32'(ball_x), cap_x);
      chk("pause_hold_y", 32'(ball_y), cap_y);
      pause = 1'b0;
      next_tick();
      chk("unpause_state", 32'(state), 2);
      next_tick();
      chk("resume_x", 32'(ball_x), cap_x + 1);

      // Rally with both paddles tracking until the speed-up has been seen.
      sp_done = 1'b0;
      for (int i = 0; i < 4000 && m_total_hits < 5; i++) begin
         play_tick(1, 1);
         if (ev_lhit) chk("left_hit_x", 32'(ball_x), 16);
         if (ev_rhit) chk("right_hit_x", 32'(ball_x), 608);
         if (ev_top) chk("top_wall_y", 32'(ball_y), 0);
         if (m_total_hits == 4 && !sp_done) begin
            sp_done = 1'b1;
            cap_x = m_bx;
            play_tick(1, 1);
            d = int'(ball_x) - cap_x;
            chk("speedup_step", (d < 0) ? -d : d, 2);
         end
      end
      chk("rally_hits", m_total_hits >= 5, 1);

      // Left paddle dodges, right tracks: right side runs out the match.
      first_point = 1'b1;
      for (int i = 0; i < 9000 && m_st != ST_GAMEOVER; i++) begin
         play_tick(2, 1);
         if (ev_point && first_point) begin
            first_point = 1'b0;
            chk("point_state", 32'(state), 1);
            chk("point_centre_x", 32'(ball_x), 312);
            chk("point_centre_y", 32'(ball_y), 232);
         end
         if (ev_point && m_rs == 8) chk("eight_still_serve", 32'(state), 1);
      end
      chk("gameover_state", 32'(state), 4);
      chk("gameover_winner", 32'(winner), 1);
      chk("gameover_r_score", 32'(r_score), 9);

      // Restart, reach play, then reset in the middle of it.
      l_up = 0; l_dn = 0; r_up = 0; r_dn = 0;
      start = 1'b1;
      next_tick();
      start = 1'b0;
      chk("restart_state", 32'(state), 1);
      chk("restart_scores", {24'd0, l_score, r_score}, 0);
      repeat (5) next_tick();
      chk("restart_play", 32'(state), 2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_values("midplay_rst");
      rst = 1'b0;
      repeat (6) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
